be_native_arbiter: RTL and testbench
====================================

Name: be_native_arbiter

Overview:
- Shares one back-end native memory port between N cache back-ends, e.g. I-cache and D-cache front ends feeding one back_end_axi-style master.
- Round-robin arbitration with one cycle of arbitration latency.
- Grant is held for a whole transaction: a single word access, or a full cache-line fill/write-back burst of 2**WORD_OFF_W beats.
- Sits between the cache back-end request logic and the shared memory/AXI adapter.

Parameters:
- N_MASTERS, 2, number of requesting ports (≥2).
- ADDR_W, 32, native address width.
- DATA_W, 32, native data width; strobe width is DATA_W/8.
- WORD_OFF_W, 3, log2 beats per burst (line size in back-end words).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- m_valid  in  N_MASTERS  per-master request.
- m_burst  in  N_MASTERS  request is a line burst of 2**WORD_OFF_W beats; sampled at grant.
- m_addr  in  N_MASTERS*ADDR_W  flattened addresses; master i occupies [i*ADDR_W +: ADDR_W].
- m_wdata  in  N_MASTERS*DATA_W  flattened write data.
- m_wstrb  in  N_MASTERS*DATA_W/8  flattened strobes; 0 means read.
- m_rdata  out  DATA_W  broadcast read data (equals s_rdata).
- m_ready  out  N_MASTERS  per-master beat acknowledge.
- s_valid  out  1  request to the shared back end.
- s_addr  out  ADDR_W  forwarded address.
- s_wdata  out  DATA_W  forwarded write data.
- s_wstrb  out  DATA_W/8  forwarded strobe.
- s_rdata  in  DATA_W  back-end read data.
- s_ready  in  1  back-end beat acknowledge.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- State on reset: state=IDLE, grant=0, rr_ptr=0, beat_cnt=0. Outputs: s_valid=0, m_ready=0, s_addr/s_wdata/s_wstrb = master 0's buses (don't-care, but deterministic).
- States: IDLE, SINGLE, BURST.
- IDLE:
  - If any m_valid is set, pick the first set index searching rr_ptr, rr_ptr+1, … modulo N_MASTERS.
  - Register that index into grant.
  - Go to BURST if m_burst[winner] is set, else SINGLE.
  - s_valid=0 in IDLE, so arbitration latency is exactly 1 cycle.
- SINGLE/BURST datapath (combinational): s_valid=m_valid[grant]; s_addr/s_wdata/s_wstrb = grant's slices; m_ready[grant]=s_ready; all other m_ready bits are 0.
- SINGLE: on s_ready=1, go to IDLE and set rr_ptr=(grant+1) mod N_MASTERS.
- BURST:
  - beat_cnt (WORD_OFF_W+1 bits) increments on every s_ready.
  - On the s_ready where beat_cnt==2**WORD_OFF_W-1: go to IDLE, clear beat_cnt, advance rr_ptr as in SINGLE.
  - The granted master may drop m_valid between beats. Grant is held and s_valid follows m_valid.
- Non-granted masters are never acknowledged and wait with valid held, per the native rule that valid holds until ready.
- A new request arriving in the same cycle as the final s_ready is seen in IDLE on the next cycle. There is always a minimum 1-cycle bubble between transactions.
- A master that deasserts valid before grant while in IDLE is simply not selected. Arbitration uses only the current-cycle m_valid.
- Reset asserted mid-transaction returns to the reset state on the next edge. The in-flight transaction is abandoned, and the back end is expected to be reset together with this block.
- m_burst on a non-granted or in-progress master is ignored after grant.
- Fairness: with all masters requesting continuously, grants rotate strictly 0,1,…,N-1; no master waits more than N-1 transactions.

Decomposition:
- Shared package/header (alongside the iob-cache defines): state encodings ARB_IDLE=0, ARB_SINGLE=1, ARB_BURST=2; the BEATS=2**WORD_OFF_W localparam.
- One natural sub-module: rr_priority_sel. It is combinational: inputs are the request vector and the pointer; outputs are the winner index and an any-request flag.
- The FSM, counter and mux stay in be_native_arbiter.

Test Plan:
- Single read: m_valid=01 with wstrb=0, addr=0x100; s_ready on the 2nd cycle after grant → s_valid first asserted the cycle after request, m_ready=01 for exactly one cycle, m_rdata=s_rdata=0xDEADBEEF, then IDLE with rr_ptr=1.
- Contention: m_valid=11 held continuously, single accesses → grant order 0,1,0,1; each m_ready pulse preceded by 1 IDLE cycle.
- Burst hold: master0 burst (WORD_OFF_W=3) with master1 requesting throughout → exactly 8 m_ready[0] pulses before any m_ready[1]. The master0 valid gap after beat 3 keeps grant 0 and holds s_valid=0 during the gap.
- Write forward: master1 wstrb=0xF, wdata=0x12345678, addr=0x2000 → s_wstrb/s_wdata/s_addr match exactly while granted; m_ready[0] stays 0.
- Reset mid-burst: assert reset after 3 of 8 beats → next cycle s_valid=0, m_ready=0, beat_cnt=0. After release, a master1 request is granted first (rr_ptr=0 but only 1 requests) and a new burst needs all 8 beats.
- Boundary: final burst beat coincides with a new m_valid[0] → IDLE for exactly one cycle, then master0 granted only if master1 is not requesting (rr_ptr advanced past 0).

Source files
------------

// File: rtl/be_native_arbiter_pkg.sv
// Shared types and helpers for the round-robin native back-end port arbiter.
package be_native_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_SINGLE = 2'd1,
        ARB_BURST  = 2'd2
    } arb_state_e;

    localparam int DEFAULT_WORD_OFF_W = 3;

    // Beats in one cache-line burst for a given word-offset width.
    function automatic int burst_beats(input int word_off_w);
        return 1 << word_off_w;
    endfunction

endpackage

// File: rtl/rr_priority_sel.sv
// Combinational round-robin selector: first set request at or after ptr_i, wrapping.
module rr_priority_sel #(
    parameter int N     = 2,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] winner_o,
    output logic             any_o
);

    logic [IDX_W-1:0] idx;

    // Scan from the farthest offset back to ptr_i so the closest request wins last.
    always_comb begin
        winner_o = '0;
        idx      = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = IDX_W'((int'(ptr_i) + k) % N);
            if (req_i[idx]) begin
                winner_o = idx;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/be_native_arbiter.sv
// Round-robin arbiter sharing one native back-end port between N cache back-ends;
// the grant is held for a whole single access or cache-line burst.
module be_native_arbiter
    import be_native_arbiter_pkg::*;
#(
    parameter int N_MASTERS  = 2,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int WORD_OFF_W = DEFAULT_WORD_OFF_W
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [N_MASTERS-1:0]            m_valid,
    input  logic [N_MASTERS-1:0]            m_burst,
    input  logic [N_MASTERS*ADDR_W-1:0]     m_addr,
    input  logic [N_MASTERS*DATA_W-1:0]     m_wdata,
    input  logic [N_MASTERS*DATA_W/8-1:0]   m_wstrb,
    output logic [DATA_W-1:0]               m_rdata,
    output logic [N_MASTERS-1:0]            m_ready,
    output logic                            s_valid,
    output logic [ADDR_W-1:0]               s_addr,
    output logic [DATA_W-1:0]               s_wdata,
    output logic [DATA_W/8-1:0]             s_wstrb,
    input  logic [DATA_W-1:0]               s_rdata,
    input  logic                            s_ready
);

    localparam int IDX_W  = $clog2(N_MASTERS);
    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = WORD_OFF_W + 1;
    localparam int BEATS  = burst_beats(WORD_OFF_W);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_MASTERS - 1);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] ptr_after_grant;
    logic             any_req;
    logic             busy;

    rr_priority_sel #(
        .N(N_MASTERS)
    ) u_sel (
        .req_i   (m_valid),
        .ptr_i   (rr_ptr_q),
        .winner_o(winner),
        .any_o   (any_req)
    );

    assign busy            = (state_q != ARB_IDLE);
    assign ptr_after_grant = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;

    assign m_rdata = s_rdata;
    assign s_valid = busy && m_valid[grant_q];

    // Forward the granted master's request; idles on the last grant (master 0 after reset).
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
        s_addr  = m_addr[0 +: ADDR_W];
        s_wdata = m_wdata[0 +: DATA_W];
        s_wstrb = m_wstrb[0 +: STRB_W];
        m_ready = '0;
        for (int i = 1; i < N_MASTERS; i++) begin
            if (grant_q == IDX_W'(i)) begin
                s_addr  = m_addr[i*ADDR_W +: ADDR_W];
                s_wdata = m_wdata[i*DATA_W +: DATA_W];
                s_wstrb = m_wstrb[i*STRB_W +: STRB_W];
            end
        end
        if (busy) begin
            m_ready[grant_q] = s_ready;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (any_req) begin
                    grant_d = winner;
                    state_d = m_burst[winner] ? ARB_BURST : ARB_SINGLE;
                end
            end
            ARB_SINGLE: begin
                if (s_ready) begin
                    state_d  = ARB_IDLE;
                    rr_ptr_d = ptr_after_grant;
                end
            end
            ARB_BURST: begin
                if (s_ready) begin
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d    = ARB_IDLE;
                        beat_cnt_d = '0;
                        rr_ptr_d   = ptr_after_grant;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ARB_IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_be_native_arbiter.sv
// Self-checking bench for be_native_arbiter: directed vector table, hand-written
// corner sequences, then random traffic against a transaction-level model.
module tb_be_native_arbiter;

    localparam int N     = 2;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int SW    = DW / 8;
    localparam int WO    = 3;
    localparam int BEATS = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  m_valid, m_burst, m_ready;
    logic [AW-1:0] a_m  [N];
    logic [DW-1:0] w_m  [N];
    logic [SW-1:0] st_m [N];
    logic [N*AW-1:0] m_addr;
    logic [N*DW-1:0] m_wdata;
    logic [N*SW-1:0] m_wstrb;
    logic [DW-1:0] m_rdata, s_wdata, s_rdata;
    logic [AW-1:0] s_addr;
    logic [SW-1:0] s_wstrb;
    logic          s_valid, s_ready;

    assign m_addr  = {a_m[1], a_m[0]};
    assign m_wdata = {w_m[1], w_m[0]};
    assign m_wstrb = {st_m[1], st_m[0]};

    always #5 clk = ~clk;

    be_native_arbiter #(
        .N_MASTERS (N),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .WORD_OFF_W(WO)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .m_valid(m_valid),
        .m_burst(m_burst),
        .m_addr (m_addr),
        .m_wdata(m_wdata),
        .m_wstrb(m_wstrb),
        .m_rdata(m_rdata),
        .m_ready(m_ready),
        .s_valid(s_valid),
        .s_addr (s_addr),
        .s_wdata(s_wdata),
        .s_wstrb(s_wstrb),
        .s_rdata(s_rdata),
        .s_ready(s_ready)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_fwd(input string tag, input int own);
        check({tag, " s_addr"},  s_addr,  a_m[own]);
        check({tag, " s_wdata"}, s_wdata, w_m[own]);
        check({tag, " s_wstrb"}, s_wstrb, st_m[own]);
    endtask

    typedef struct {
        logic [1:0] mv;
        logic [1:0] mb;
        logic       sr;
        logic       exp_sv;
        logic [1:0] exp_mr;
        int         exp_own;
    } vec_t;

    vec_t vecs [13];

    // Transaction-level reference model state for the random phase.
    int owner, ptr, beats_left, j, beats, gap;
    bit cur_burst;
    bit pend [N];
    bit in_gap, exp_sv;
    logic [1:0] exp_mr;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single read from master 0, then continuous contention with single accesses.
        vecs[0]  = '{2'b01, 2'b00, 1'b0, 1'b0, 2'b00, 0};
        vecs[1]  = '{2'b01, 2'b00, 1'b0, 1'b1, 2'b00, 0};
        vecs[2]  = '{2'b01, 2'b00, 1'b1, 1'b1, 2'b01, 0};
        vecs[3]  = '{2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 0};
        vecs[4]  = '{2'b11, 2'b00, 1'b0, 1'b0, 2'b00, 0};
        vecs[5]  = '{2'b11, 2'b00, 1'b1, 1'b1, 2'b10, 1};
        vecs[6]  = '{2'b11, 2'b00, 1'b0, 1'b0, 2'b00, 0};
        vecs[7]  = '{2'b11, 2'b00, 1'b1, 1'b1, 2'b01, 0};
        vecs[8]  = '{2'b11, 2'b00, 1'b0, 1'b0, 2'b00, 0};
        vecs[9]  = '{2'b11, 2'b00, 1'b1, 1'b1, 2'b10, 1};
        vecs[10] = '{2'b11, 2'b00, 1'b0, 1'b0, 2'b00, 0};
        vecs[11] = '{2'b11, 2'b00, 1'b1, 1'b1, 2'b01, 0};
        vecs[12] = '{2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 0};

        reset   = 1'b1;
        m_valid = '0;
        m_burst = '0;
        s_ready = 1'b0;
        s_rdata = 32'hDEADBEEF;
        a_m[0] = 32'h0000_0100; w_m[0] = 32'h0;         st_m[0] = 4'h0;
        a_m[1] = 32'h0000_2000; w_m[1] = 32'h1234_5678; st_m[1] = 4'hF;
        tick();
        tick();

        // Reset state: requests and ready during reset are ignored.
        m_valid = 2'b01;
        s_ready = 1'b1;
        @(negedge clk);
        check("reset s_valid", s_valid, 1'b0);
        check("reset m_ready", m_ready, 2'b00);
        check("reset s_addr", s_addr, 32'h0000_0100);
        tick();
        reset = 1'b0;

        for (int v = 0; v < 13; v++) begin
            m_valid = vecs[v].mv;
            m_burst = vecs[v].mb;
            s_ready = vecs[v].sr;
            @(negedge clk);
            check($sformatf("vec%0d s_valid", v), s_valid, vecs[v].exp_sv);
            check($sformatf("vec%0d m_ready", v), m_ready, vecs[v].exp_mr);
            check($sformatf("vec%0d m_rdata", v), m_rdata, 32'hDEADBEEF);
            if (vecs[v].exp_sv) begin
                check_fwd($sformatf("vec%0d", v), vecs[v].exp_own);
            end
            tick();
        end

        // Burst hold: master 0 alone wins (pointer is at 1), then master 1 requests throughout.
        m_valid = 2'b01;
        m_burst = 2'b01;
        s_ready = 1'b0;
        @(negedge clk);
        check("burst-hold arb bubble", s_valid, 1'b0);
        tick();
        beats = 0;
        gap   = 0;
        for (int c = 0; c < 40 && beats < BEATS; c++) begin
            in_gap  = (beats == 3) && (gap < 2);
            m_valid = {1'b1, !in_gap};
            m_burst = 2'b00;
            s_ready = !in_gap;
            @(negedge clk);
            if (in_gap) begin
                check($sformatf("burst-hold gap%0d s_valid", gap), s_valid, 1'b0);
                check($sformatf("burst-hold gap%0d m_ready", gap), m_ready, 2'b00);
                gap++;
            end else begin
                check($sformatf("burst-hold beat%0d m_ready", beats), m_ready, 2'b01);
                check($sformatf("burst-hold beat%0d s_addr", beats), s_addr, 32'h0000_0100);
                beats++;
            end
            tick();
        end
        check("burst-hold beat count", beats, BEATS);
        m_valid = 2'b11;
        s_ready = 1'b0;
        @(negedge clk);
        check("burst-hold post bubble", s_valid, 1'b0);
        tick();
        s_ready = 1'b1;
        @(negedge clk);
        check("burst-hold then m1 m_ready", m_ready, 2'b10);
        check_fwd("burst-hold then m1", 1);
        tick();
        m_valid = 2'b00;
        s_ready = 1'b0;
        tick();

        // Reset after 3 of 8 beats abandons the burst and clears the beat counter.
        m_valid = 2'b01;
        m_burst = 2'b01;
        tick();
        for (int b = 0; b < 3; b++) begin
            s_ready = 1'b1;
            @(negedge clk);
            check($sformatf("pre-reset beat%0d m_ready", b), m_ready, 2'b01);
            tick();
        end
        reset = 1'b1;
        tick();
        @(negedge clk);
        check("mid-reset s_valid", s_valid, 1'b0);
        check("mid-reset m_ready", m_ready, 2'b00);
        tick();
        reset   = 1'b0;
        m_valid = 2'b10;
        m_burst = 2'b10;
        s_ready = 1'b0;
        @(negedge clk);
        check("post-reset arb bubble", s_valid, 1'b0);
        tick();
        for (int b = 0; b < BEATS; b++) begin
            s_ready = 1'b1;
            @(negedge clk);
            check($sformatf("post-reset m1 beat%0d m_ready", b), m_ready, 2'b10);
            tick();
        end
        m_burst = 2'b00;
        @(negedge clk);
        check("post-reset burst end s_valid", s_valid, 1'b0);
        tick();
        @(negedge clk);
        check("post-reset m1 single m_ready", m_ready, 2'b10);
        tick();
        m_valid = 2'b00;
        s_ready = 1'b0;
        tick();

        // Final burst beat coincides with a fresh master 0 request.
        m_valid = 2'b01;
        m_burst = 2'b01;
        tick();
        for (int b = 0; b < BEATS; b++) begin
            m_burst = 2'b00;
            s_ready = 1'b1;
            @(negedge clk);
            check($sformatf("boundary beat%0d m_ready", b), m_ready, 2'b01);
            tick();
        end
        m_valid = 2'b11;
        s_ready = 1'b0;
        @(negedge clk);
        check("boundary bubble s_valid", s_valid, 1'b0);
        tick();
        s_ready = 1'b1;
        @(negedge clk);
        check("boundary m1 wins m_ready", m_ready, 2'b10);
        tick();
        m_valid = 2'b01;
        s_ready = 1'b0;
        @(negedge clk);
        check("boundary m0 bubble s_valid", s_valid, 1'b0);
        tick();
        s_ready = 1'b1;
        @(negedge clk);
        check("boundary m0 alone m_ready", m_ready, 2'b01);
        tick();
        m_valid = 2'b00;
        s_ready = 1'b0;

        // Random traffic against the transaction-level model.
        reset = 1'b1;
        tick();
        tick();
        reset      = 1'b0;
        owner      = -1;
        ptr        = 0;
        beats_left = 0;
        cur_burst  = 1'b0;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;

        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(2) == 0) begin
                    pend[i]    = 1'b1;
                    m_burst[i] = 1'($urandom_range(1));
                    a_m[i]     = $urandom;
                    w_m[i]     = $urandom;
                    st_m[i]    = ($urandom_range(1) == 1) ? SW'($urandom) : '0;
                end
                m_valid[i] = pend[i];
                if (owner == i && cur_burst && beats_left < BEATS && $urandom_range(3) == 0) begin
                    m_valid[i] = 1'b0;
                end
            end
            exp_sv  = (owner >= 0) && m_valid[owner];
            s_ready = exp_sv && ($urandom_range(1) == 1);
            s_rdata = $urandom;
            exp_mr  = (owner >= 0 && s_ready) ? (2'b01 << owner) : 2'b00;
            @(negedge clk);
            check($sformatf("rnd%0d s_valid", cyc), s_valid, exp_sv);
            check($sformatf("rnd%0d m_ready", cyc), m_ready, exp_mr);
            check($sformatf("rnd%0d m_rdata", cyc), m_rdata, s_rdata);
            if (exp_sv) begin
                check_fwd($sformatf("rnd%0d", cyc), owner);
            end
            if (owner < 0) begin
                for (int k = 0; k < N; k++) begin
                    j = (ptr + k) % N;
                    if (owner < 0 && m_valid[j]) begin
                        owner      = j;
                        cur_burst  = m_burst[j];
                        beats_left = cur_burst ? BEATS : 1;
                    end
                end
            end else if (s_ready) begin
                beats_left--;
                if (beats_left == 0) begin
                    pend[owner] = 1'b0;
                    ptr         = (owner + 1) % N;
                    owner       = -1;
                end
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
